// File: rtl/seq_det_sequencer_if.sv
// seq_det_sequencer_if: host and detector-side signals of the sequence
// detector sequencer, bundled into one interface.
// Optional macro SEQ_DET_SEQUENCER_CONT_EN adds the 'cont' request bit.
// slave  : the sequencer's view (drives busy/done/results and det_in/det_rst_n).
// master : the host plus detector view (drives start/data/abort and det_seq_out).
interface seq_det_sequencer_if #(
  parameter int WORD_W = 24,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [WORD_W-1:0] data;
  logic              abort;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  hit_cnt;
  logic [WORD_W-1:0] hit_map;
  logic              det_in;
  logic              det_rst_n;
  logic              det_seq_out;
`ifdef SEQ_DET_SEQUENCER_CONT_EN
  logic              cont;

  modport slave (
    input  start, data, abort, cont, det_seq_out,
    output busy, done, hit_cnt, hit_map, det_in, det_rst_n
  );

  modport master (
    output start, data, abort, cont, det_seq_out,
    input  busy, done, hit_cnt, hit_map, det_in, det_rst_n
  );
`else
  modport slave (
    input  start, data, abort, det_seq_out,
    output busy, done, hit_cnt, hit_map, det_in, det_rst_n
  );

  modport master (
    output start, data, abort, det_seq_out,
    input  busy, done, hit_cnt, hit_map, det_in, det_rst_n
  );
`endif
endinterface

// File: rtl/seq_det_sequencer.sv
// seq_det_sequencer: accepts a test word, clears the external shift-register
// sequence detector, streams the word MSB-first into it and records which
// bit positions produced a match (hit_map) plus a saturating hit count.
// Optional macro SEQ_DET_SEQUENCER_CONT_EN: a start with cont=1 skips the
// detector clear so patterns spanning consecutive words are detected.
module seq_det_sequencer #(
  parameter int WORD_W     = 24,
  parameter int CNT_W      = 8,
  parameter int CLR_CYCLES = 2,
  parameter int DET_LAT    = 1
) (
  input logic                clk,
  input logic                reset,
  seq_det_sequencer_if.slave sif
);

  // One counter serves CLEAR (cycle index) and SHIFT+DRAIN (step t).
  localparam int MAXC = (WORD_W + DET_LAT > CLR_CYCLES) ? WORD_W + DET_LAT : CLR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]     CLR_LAST   = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0]     SHIFT_LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0]     DRAIN_LAST = CW'(WORD_W + DET_LAT - 1);
  localparam logic [CW-1:0]     LAT_C      = CW'(DET_LAT);
  localparam logic [WORD_W-1:0] TOP_BIT    = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              det_in_q, det_in_d;
  logic              det_rst_n_q, det_rst_n_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [WORD_W-1:0] hit_map_q, hit_map_d;
  logic              sample_en;

  // Hit counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, serial stream and result accumulation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    det_in_d    = 1'b0;
    det_rst_n_d = 1'b1;
    hit_cnt_d   = hit_cnt_q;
    hit_map_d   = hit_map_q;
    sample_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (sif.start) begin
          sh_d      = sif.data;
          hit_cnt_d = '0;
          hit_map_d = '0;
          busy_d    = 1'b1;
          cnt_d     = '0;
`ifdef SEQ_DET_SEQUENCER_CONT_EN
          if (sif.cont) begin
            // Keep detector history: first bit goes out right away.
            state_d  = S_SHIFT;
            det_in_d = sif.data[WORD_W-1];
            sh_d     = sif.data << 1;
          end else begin
            state_d     = S_CLEAR;
            det_rst_n_d = 1'b0;
          end
`else
          state_d     = S_CLEAR;
          det_rst_n_d = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        if (sif.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CLR_LAST) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          det_in_d = sh_q[WORD_W-1];
          sh_d     = sh_q << 1;
        end else begin
          cnt_d       = cnt_q + CW'(1);
          det_rst_n_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (sif.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          sample_en = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == SHIFT_LAST) begin
            state_d = S_DRAIN;
          end else begin
            det_in_d = sh_q[WORD_W-1];
            sh_d     = sh_q << 1;
          end
        end
      end
      S_DRAIN: begin
        if (sif.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          sample_en = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == DRAIN_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        // abort is deliberately ignored here so the job completes.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Result at step t belongs to bit k = t - DET_LAT, stored at WORD_W-1-k.
    if (sample_en && (cnt_q >= LAT_C) && sif.det_seq_out) begin
      hit_cnt_d = sat_inc(hit_cnt_q);
      hit_map_d = hit_map_q | (TOP_BIT >> (cnt_q - LAT_C));
    end
  end

  // State and registered outputs; reset forces the detector into reset too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_in_q    <= 1'b0;
      det_rst_n_q <= 1'b0;
      hit_cnt_q   <= '0;
      hit_map_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      det_in_q    <= det_in_d;
      det_rst_n_q <= det_rst_n_d;
      hit_cnt_q   <= hit_cnt_d;
      hit_map_q   <= hit_map_d;
    end
  end

  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.det_in    = det_in_q;
  assign sif.det_rst_n = det_rst_n_q;
  assign sif.hit_cnt   = hit_cnt_q;
  assign sif.hit_map   = hit_map_q;

endmodule

// File: tb/tb_seq_det_sequencer.sv
// Bench for seq_det_sequencer: detector stub, scoreboard with a monitor that
// checks every done pulse, and a directed + randomized job driver.
module tb_seq_det_sequencer;

  localparam int W      = 24;
  localparam int CNT_W  = 4;
  localparam int CLR    = 2;
  localparam int LAT    = 1;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_det_sequencer_if #(.WORD_W(W), .CNT_W(CNT_W)) sif();

  seq_det_sequencer #(
    .WORD_W(W), .CNT_W(CNT_W), .CLR_CYCLES(CLR), .DET_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sif(sif)
  );

  // Detector stub: det_in delayed LAT cycles, cleared while det_rst_n is low.
  logic [LAT:0] pipe;
  always @(posedge clk) begin
    if (!sif.det_rst_n) pipe <= '0;
    else                pipe <= {pipe[LAT-1:0], sif.det_in};
  end
  assign sif.det_seq_out = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0]     map;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the stub is a pure delay, so the result for streamed bit k is
  // data bit k itself; only the first nsamp bits have been sampled.
  function automatic void model(input logic [W-1:0] d, input int nsamp,
                                output logic [W-1:0] m, output logic [CNT_W-1:0] c);
    int hits;
    hits = 0;
    m = '0;
    for (int k = 0; k < nsamp && k < W; k++) begin
      if (d[W-1-k]) begin
        m[W-1-k] = 1'b1;
        hits++;
      end
    end
    c = CNT_W'((hits > MAXCNT) ? MAXCNT : hits);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding job.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && sif.done === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hit_map", 64'(sif.hit_map), 64'(e.map));
          chk("hit_cnt", 64'(sif.hit_cnt), 64'(e.cnt));
          chk("busy_in_done", 64'(sif.busy), 64'd1);
        end
      end
    end
  end

  // Runs one job. collide_at/abort_at are cycle indices after the accepting
  // edge (cycle 0 = first cycle after it); -1 disables. aws = abort with start.
  task automatic run_job(input logic [W-1:0] d, input bit use_cont,
                         input int collide_at, input logic [W-1:0] cd,
                         input int abort_at, input bit aws);
    int off, lat, e0, rst_low, n, nsamp;
    logic [W-1:0] stream_obs, em;
    logic [CNT_W-1:0] ec;
    exp_t e;
    off = use_cont ? 0 : CLR;
    lat = off + W + LAT;
    n = 0;
    @(negedge clk);
    while (sif.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", 64'(sif.busy), 64'd0);
    sif.start = 1'b1;
    sif.data  = d;
    sif.abort = aws;
`ifdef SEQ_DET_SEQUENCER_CONT_EN
    sif.cont  = use_cont;
`endif
    @(posedge clk);
    #1;
    e0 = cyc;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.data  = W'($urandom);
`ifdef SEQ_DET_SEQUENCER_CONT_EN
    sif.cont  = 1'($urandom);
`endif
    if (abort_at < 0 || abort_at >= lat) begin
      model(d, W, em, ec);
      e.map = em;
      e.cnt = ec;
      e.cyc = e0 + lat;
      sbq.push_back(e);
    end
    rst_low = 0;
    stream_obs = '0;
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      if (sif.det_rst_n !== 1'b1) rst_low++;
      if (j >= off && j < off + W) stream_obs[W-1-(j-off)] = sif.det_in;
      sif.start = (j == collide_at);
      if (j == collide_at) sif.data = cd;
      sif.abort = (j == abort_at);
      if (j == abort_at && abort_at < lat) begin
        @(negedge clk);
        sif.abort = 1'b0;
        nsamp = (j - off) - LAT;
        if (nsamp < 0) nsamp = 0;
        model(d, nsamp, em, ec);
        chk("abort_busy", 64'(sif.busy), 64'd0);
        chk("abort_det_rst_n", 64'(sif.det_rst_n), 64'd1);
        chk("abort_det_in", 64'(sif.det_in), 64'd0);
        chk("abort_hit_cnt", 64'(sif.hit_cnt), 64'(ec));
        chk("abort_hit_map", 64'(sif.hit_map), 64'(em));
        repeat (3) @(negedge clk);
        return;
      end
    end
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk("det_in_stream", 64'(stream_obs), 64'(d));
    chk("det_rst_n_low_cycles", 64'(rst_low), 64'(off));
    @(negedge clk);
    model(d, W, em, ec);
    chk("busy_after_done", 64'(sif.busy), 64'd0);
    chk("hold_hit_map", 64'(sif.hit_map), 64'(em));
    chk("hold_hit_cnt", 64'(sif.hit_cnt), 64'(ec));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},      64'(sif.busy),      64'd0);
    chk({tag, "_done"},      64'(sif.done),      64'd0);
    chk({tag, "_det_in"},    64'(sif.det_in),    64'd0);
    chk({tag, "_det_rst_n"}, 64'(sif.det_rst_n), 64'd0);
    chk({tag, "_hit_cnt"},   64'(sif.hit_cnt),   64'd0);
    chk({tag, "_hit_map"},   64'(sif.hit_map),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    bit c;
    int lat, col, ab;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.data  = '0;
`ifdef SEQ_DET_SEQUENCER_CONT_EN
    sif.cont  = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    reset = 1'b0;
    @(negedge clk);
    chk("first_idle_det_rst_n", 64'(sif.det_rst_n), 64'd1);

    // Basic job, saturation, collision, abort, start+abort, abort in DONE.
    run_job(24'h2B5C56, 1'b0, -1, '0, -1, 1'b0);
    run_job(24'hFFFFFF, 1'b0, -1, '0, -1, 1'b0);
    run_job(24'h2B5C56, 1'b0, 5, 24'h000001, -1, 1'b0);
    run_job(24'hFFFFFF, 1'b0, -1, '0, CLR + 10, 1'b0);
    run_job(24'h3C96E1, 1'b0, -1, '0, -1, 1'b1);
    run_job(24'h81F00F, 1'b0, -1, '0, CLR + W + LAT, 1'b0);
    run_job(24'h7E0011, 1'b0, -1, '0, 1, 1'b0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    sif.start = 1'b1;
    sif.data  = 24'h5A5A5A;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (CLR + 6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_det_rst_n", 64'(sif.det_rst_n), 64'd1);
    chk("post_reset_busy", 64'(sif.busy), 64'd0);
    run_job(24'hA5A5A5, 1'b0, -1, '0, -1, 1'b0);

`ifdef SEQ_DET_SEQUENCER_CONT_EN
    run_job(24'h2B5C56, 1'b0, -1, '0, -1, 1'b0);
    run_job(24'h13579B, 1'b1, -1, '0, -1, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      d = W'($urandom);
      c = 1'b0;
`ifdef SEQ_DET_SEQUENCER_CONT_EN
      c = 1'($urandom);
`endif
      lat = (c ? 0 : CLR) + W + LAT;
      col = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      run_job(d, c, col, W'($urandom), ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_sequencer.md
Name: seq_det_sequencer

Overview:
- Controller that sequences the shift-register sequence detector: accepts a parallel test word over a start/busy handshake, clears the detector, and streams the word MSB-first into the detector's serial input.
- Samples the detector's match output for every bit, building a per-bit hit map and a saturating hit count, then signals done.
- Sits between the host/bench logic and one detector instance. The detector is an external instance driven through the det_* ports.

Parameters:
- WORD_W, 24, number of bits streamed per job.
- CNT_W, 8, width of hit_cnt.
- CLR_CYCLES, 2, cycles det_rst_n is held low before streaming (>=1).
- DET_LAT, 1, clock cycles from a bit appearing on det_in to its det_seq_out result being valid (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted only when busy=0 and state IDLE.
- data  in  WORD_W  word to stream; latched on the accepting edge.
- abort  in  1  synchronous cancel of the running job.
- busy  out  1  high from the accepting edge until return to IDLE.
- done  out  1  one-cycle pulse, results valid.
- hit_cnt  out  CNT_W  number of bit positions with det_seq_out=1, saturating.
- hit_map  out  WORD_W  hit_map[i]=1 iff the result for data[i] was 1.
- det_in  out  1  serial bit to the detector.
- det_rst_n  out  1  active-low detector reset.
- det_seq_out  in  1  detector match output.

Behaviour:
- All outputs are registered.
- Async reset values: state=IDLE, busy=0, done=0, det_in=0, det_rst_n=0, hit_cnt=0, hit_map=0, internal counters=0.
- After reset release, the first edge in IDLE drives det_rst_n=1.
- FSM transitions:
  - IDLE: on start, latch data, clear hit_cnt and hit_map, set busy=1, go to CLEAR.
  - CLEAR: det_rst_n=0 and det_in=0 for CLR_CYCLES cycles, then go to SHIFT.
  - SHIFT: WORD_W cycles. In SHIFT cycle k (k=0..WORD_W-1), det_in=word[WORD_W-1-k] and det_rst_n=1. Then go to DRAIN.
  - DRAIN: DET_LAT cycles with det_in=0, then go to DONE.
  - DONE: one cycle with done=1 and busy=1, then go to IDLE with busy=0.
- Sampling:
  - A global step counter t counts from 0 at the first SHIFT cycle through the end of DRAIN.
  - When t>=DET_LAT, det_seq_out belongs to bit k=t-DET_LAT. If it is 1, set hit_map[WORD_W-1-k] and increment hit_cnt.
  - Exactly WORD_W samples are taken per job.
- hit_cnt saturates at 2^CNT_W-1 and never wraps.
- Results hold their values after DONE until the next accepted start.
- Latency: for a start accepted at edge E0, done rises at edge E0+CLR_CYCLES+WORD_W+DET_LAT (E0+27 with defaults).
- start while busy: ignored. No queueing; data is not re-latched.
- start and abort asserted together in IDLE: abort has no effect and start is accepted.
- abort in CLEAR, SHIFT or DRAIN:
  - Next edge goes to IDLE with busy=0, det_in=0, det_rst_n=1.
  - done is not pulsed.
  - hit_cnt and hit_map keep their partial values.
- abort in DONE: ignored, and done completes.
- reset mid-job: immediate return to reset values. No done pulse.

Optional Feature:
- Macro SEQ_DET_SEQUENCER_CONT_EN.
- Defined: adds input port cont (1 bit), sampled together with start. When cont=1 on the accepting edge, the CLEAR state is skipped (IDLE goes directly to SHIFT, det_rst_n stays 1). The detector keeps its history from the previous job, so patterns spanning the word boundary are detected. Latency becomes WORD_W+DET_LAT.
- Not defined: no cont port, and CLEAR is always executed.

Test Plan:
- Bench detector stub: det_seq_out is det_in delayed DET_LAT cycles, and the stub is cleared while det_rst_n=0.
- Basic job: start with data=24'h2B5C56 -> det_in streams 001010110101110001010110 during SHIFT; done rises at E0+27; hit_map=24'h2B5C56; hit_cnt=12.
- Saturation: CNT_W=4, data=24'hFFFFFF -> hit_cnt=15 (no wrap); hit_map=24'hFFFFFF.
- Busy collision: second start with data=24'h000001 asserted 5 cycles after the first job (24'h2B5C56) is accepted -> ignored; results equal the first job; a single done pulse.
- Abort: abort after 10 SHIFT cycles of 24'hFFFFFF -> IDLE next edge; busy=0; no done; det_rst_n=1; hit_cnt=9 (samples t=1..9).
- Reset mid-SHIFT: reset pulsed during SHIFT -> all outputs at reset values immediately; after release, a fresh job with 24'hA5A5A5 gives hit_cnt=12.
- CONT_EN: back-to-back jobs with cont=1 on the second -> no det_rst_n low pulse; second done at E0+25.
